uart_tx: RTL and testbench

UART transmitter that serialises one 8-bit word per frame onto `txd`: start bit, 8 data bits LSB first, an optional even/odd parity bit, then 1 or 2 stop bits. Each serial bit lasts exactly one `clock` cycle; any baud-rate division is handled outside this block by gating `clock` or `tx_en`. It sits behind the UART register interface, which presents a word with a one-cycle `data_valid` strobe and polls `tx_rdy`.

---
 rtl/uart_tx.sv | 112 +++++++++++
 tb/tb_uart_tx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: one serial bit per clock, start + 8 data (LSB first) +
// optional even/odd parity + 1 or 2 stop bits. txd/tx_rdy are registered.
module uart_tx (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_en,
  input  logic [1:0] parity_type,
  input  logic       nstop,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       txd,
  output logic       tx_rdy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } state_t;

  state_t      present_state;
  logic [2:0]  bit_cnt;
  logic [7:0]  data_q;
  logic [1:0]  parity_q;
  logic        nstop_q;

  // Outputs are registered alongside the state, so each branch drives the
  // txd/tx_rdy values that belong to the state being entered.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every register update reading the
    // pre-edge values, which is what makes this a clean single-edge FSM.
    if (reset) begin
      present_state <= ST_IDLE;
      bit_cnt       <= 3'd0;
      // NOTE: the frame registers are reset too, although each frame reloads
      // them, so nothing downstream can ever see X after reset.
      data_q        <= 8'd0;
      parity_q      <= 2'd0;
      nstop_q       <= 1'b0;
      txd           <= 1'b1;
      tx_rdy        <= 1'b1;
    end else begin
      case (present_state)
        ST_IDLE: begin
          if (tx_en && data_valid) begin
            present_state <= ST_START;
            data_q        <= data_in;
            parity_q      <= parity_type;
            nstop_q       <= nstop;
            bit_cnt       <= 3'd0;
            txd           <= 1'b0;
            tx_rdy        <= 1'b0;
          end else begin
            txd    <= 1'b1;
            tx_rdy <= 1'b1;
          end
        end

        ST_START: begin
          present_state <= ST_DATA;
          txd           <= data_q[bit_cnt];
          tx_rdy        <= 1'b0;
        end

        ST_DATA: begin
          tx_rdy <= 1'b0;
          if (bit_cnt == 3'd7) begin
            bit_cnt <= 3'd0;
            if (parity_q[1]) begin
              present_state <= ST_PARITY;
              txd           <= (^data_q) ^ parity_q[0];
            end else begin
              present_state <= ST_STOP1;
              txd           <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            txd     <= data_q[bit_cnt + 3'd1];
          end
        end

        ST_PARITY: begin
          present_state <= ST_STOP1;
          txd           <= 1'b1;
          tx_rdy        <= 1'b0;
        end

        ST_STOP1: begin
          txd <= 1'b1;
          if (nstop_q) begin
            present_state <= ST_STOP2;
            tx_rdy        <= 1'b0;
          end else begin
            present_state <= ST_IDLE;
            tx_rdy        <= 1'b1;
          end
        end

        // Stop2 and the unused encodings all return to Idle.
        default: begin
          present_state <= ST_IDLE;
          txd           <= 1'b1;
          tx_rdy        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-list reference model compared every
// cycle, plus hand-computed frames that pin the model.
module tb_uart_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx_en = 1'b0;
  logic [1:0] parity_type = 2'b00;
  logic       nstop = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       txd;
  logic       tx_rdy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int frames = 0;

  uart_tx dut (
    .clock       (clock),
    .reset       (reset),
    .tx_en       (tx_en),
    .parity_type (parity_type),
    .nstop       (nstop),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .txd         (txd),
    .tx_rdy      (tx_rdy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a started frame is just a list of (line level, state)
  // beats, played out one per clock; an empty list means Idle.
  typedef struct packed {
    logic       bit_val;
    logic [2:0] st;
  } beat_t;

  beat_t q[$];
  beat_t cur;

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      cur = '{1'b1, 3'd0};
    end else if (cur.st == 3'd0 && tx_en && data_valid) begin
      q.push_back('{1'b0, 3'd1});
      for (int j = 0; j < 8; j++) q.push_back('{data_in[j], 3'd2});
      if (parity_type[1]) q.push_back('{(^data_in) ^ parity_type[0], 3'd3});
      q.push_back('{1'b1, 3'd4});
      if (nstop) q.push_back('{1'b1, 3'd5});
      cur = q.pop_front();
      frames++;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = '{1'b1, 3'd0};
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("model_state", 32'(dut.present_state), 32'(cur.st));
      check("model_txd", 32'(txd), 32'(cur.bit_val));
      check("model_rdy", 32'(tx_rdy), 32'(cur.st == 3'd0));
    end
  end

  // Strobe one word, then record n cycles of txd/state; optionally scramble
  // every input while the frame is in flight.
  task automatic send_capture(input logic [7:0] d, input logic [1:0] p, input logic ns,
                              input int n, input bit scramble,
                              output logic [11:0] bits, output logic [35:0] sts,
                              output logic rdy_seen);
    @(negedge clock);
    data_in = d; parity_type = p; nstop = ns; tx_en = 1'b1; data_valid = 1'b1;
    bits = '1; sts = '0; rdy_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bits[i] = txd;
      sts[3*i +: 3] = dut.present_state;
      rdy_seen |= tx_rdy;
      if (scramble && i < n - 1) begin
        tx_en = 1'($urandom); data_valid = 1'($urandom);
        data_in = 8'($urandom); parity_type = 2'($urandom); nstop = 1'($urandom);
      end else begin
        data_valid = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_txd"}, 32'(txd), 32'd1);
    check({name, "_rdy"}, 32'(tx_rdy), 32'd1);
    check({name, "_state"}, 32'(dut.present_state), 32'd0);
  endtask

  logic [11:0] bits;
  logic [35:0] sts;
  logic        rdy_seen;
  int          exp_st[12] = '{1, 2, 2, 2, 2, 2, 2, 2, 2, 3, 4, 5};
  int          starts;
  int          base;
  bit          done;

  initial begin
    // Reset
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_idle("reset");
    reset = 1'b0;
    cmp_en = 1'b1;

    // Request with tx_en low is dropped
    tx_en = 1'b0; data_valid = 1'b1; data_in = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("disabled_rdy", 32'(tx_rdy), 32'd1);
    end
    data_valid = 1'b0;

    // 0xA5, no parity, one stop
    send_capture(8'hA5, 2'b00, 1'b0, 10, 1'b0, bits, sts, rdy_seen);
    check("a5_bits", 32'(bits), 32'h0F4A);
    check("a5_rdy_low", 32'(rdy_seen), 32'd0);
    @(negedge clock);
    check_idle("a5_after");

    // 0x07, even parity, two stops
    send_capture(8'h07, 2'b10, 1'b1, 12, 1'b0, bits, sts, rdy_seen);
    check("even_bits", 32'(bits), 32'h0E0E);
    for (int i = 0; i < 12; i++) check("even_state", 32'(sts[3*i +: 3]), 32'(exp_st[i]));
    @(negedge clock);
    check_idle("even_after");

    // 0x07, odd parity, one stop
    send_capture(8'h07, 2'b11, 1'b0, 11, 1'b0, bits, sts, rdy_seen);
    check("odd_bits", 32'(bits), 32'h0C0E);
    @(negedge clock);
    check_idle("odd_after");

    // 0x3C, odd parity, two stops, inputs scrambled mid-frame
    send_capture(8'h3C, 2'b11, 1'b1, 12, 1'b1, bits, sts, rdy_seen);
    check("scramble_bits", 32'(bits), 32'h0E78);
    check("scramble_rdy_low", 32'(rdy_seen), 32'd0);
    @(negedge clock);
    check_idle("scramble_after");

    // Reset during data bit 3
    send_capture(8'hFF, 2'b00, 1'b0, 5, 1'b0, bits, sts, rdy_seen);
    check("pre_reset_state", 32'(sts[12 +: 3]), 32'd2);
    reset = 1'b1;
    @(negedge clock);
    check_idle("midreset");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // data_valid held high: one frame per Idle visit, 11-cycle period
    data_in = 8'h81; parity_type = 2'b00; nstop = 1'b0; tx_en = 1'b1; data_valid = 1'b1;
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (dut.present_state == 3'd1) starts++;
    end
    data_valid = 1'b0;
    check("held_valid_starts", 32'(starts), 32'd3);
    repeat (13) @(negedge clock);

    // 1000 random frames against the model, with rare resets
    base = frames;
    done = 1'b0;
    for (int c = 0; c < 40000 && !done; c++) begin
      @(negedge clock);
      tx_en = ($urandom_range(0, 3) != 0);
      data_valid = ($urandom_range(0, 2) == 0);
      data_in = 8'($urandom);
      parity_type = 2'($urandom);
      nstop = 1'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      if (frames - base >= 1000) done = 1'b1;
    end
    check("random_frames_done", 32'(done), 32'd1);
    reset = 1'b0; data_valid = 1'b0;
    repeat (15) @(negedge clock);
    check_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
